// File: rtl/nec_ir_decoder.sv
// NEC infrared frame decoder: synchronizes the demodulator output, times each burst/space,
// validates the 32-bit frame and holds the command byte while repeat codes keep arriving.
module nec_ir_decoder #(
   parameter int unsigned TICK_DIV   = 500,
   parameter int unsigned HOLD_TICKS = 12000,
   parameter logic [7:0]  IDLE_CODE  = 8'h00,
   parameter bit          CHECK_ADDR = 1'b1
) (
   input  logic       clk_50,
   input  logic       reset_n,
   input  logic       ir_in,
   output logic [7:0] IR_button,
   output logic       code_valid,
   output logic       repeat_seen,
   output logic       frame_err
);
   localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int HW = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS + 1) : 1;
   localparam logic [PW-1:0] PRE_LAST  = PW'(TICK_DIV - 1);
   localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_TICKS);
   localparam logic [10:0]   TMR_MAX   = 11'd2047;

   typedef enum logic [2:0] {IDLE, LEAD_LOW, LEAD_HIGH, BIT_LOW, BIT_HIGH, STOP} state_t;

   logic          sync1_q, sync2_q, sync3_q, rise_q, fall_q;
   logic [PW-1:0] pre_q;
   logic [10:0]   tmr_q;
   state_t        state_q;
   logic          rpt_q;
   logic [5:0]    bitcnt_q;
   logic [31:0]   sr_q;
   logic [HW-1:0] hold_q;
   logic [7:0]    button_q;
   logic          valid_q, rseen_q, err_q;
   logic          tick, edge_seen, timeout, stop_ok, sum_ok, frame_ok, rpt_ok;

   function automatic logic in_rng(input logic [10:0] t, input logic [10:0] lo,
                                   input logic [10:0] hi);
      return (t >= lo) && (t <= hi);
   endfunction

   // Timer values beyond which the expected edge can no longer be valid.
   function automatic logic [10:0] limit_of(input state_t s);
      case (s)
         LEAD_LOW:  return 11'd1001;
         LEAD_HIGH: return 11'd501;
         BIT_HIGH:  return 11'd201;
         default:   return 11'd73;
      endcase
   endfunction

   assign tick      = (pre_q == PRE_LAST);
   assign edge_seen = rise_q | fall_q;
   assign timeout   = (state_q != IDLE) && !edge_seen && (tmr_q > limit_of(state_q));
   assign stop_ok   = (state_q == STOP) && rise_q && in_rng(tmr_q, 11'd40, 11'd72);
   assign sum_ok    = ((sr_q[23:16] ^ sr_q[31:24]) == 8'hFF) &&
                      (!CHECK_ADDR || ((sr_q[7:0] ^ sr_q[15:8]) == 8'hFF));
   assign frame_ok  = stop_ok && !rpt_q && sum_ok;
   assign rpt_ok    = stop_ok && rpt_q && (hold_q != '0);

   assign IR_button   = button_q;
   assign code_valid  = valid_q;
   assign repeat_seen = rseen_q;
   assign frame_err   = err_q;

   // Line idles high, so the synchronizer resets to 1 to avoid a phantom edge.
   always_ff @(posedge clk_50 or negedge reset_n) begin
      if (!reset_n) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
         sync3_q <= 1'b1;
         rise_q  <= 1'b0;
         fall_q  <= 1'b0;
         pre_q   <= '0;
         tmr_q   <= '0;
      end else begin
         sync1_q <= ir_in;
         sync2_q <= sync1_q;
         sync3_q <= sync2_q;
         rise_q  <= sync2_q & ~sync3_q;
         fall_q  <= ~sync2_q & sync3_q;
         pre_q   <= tick ? '0 : pre_q + PW'(1);
         if (edge_seen)
            tmr_q <= '0;
         else if (tick && tmr_q != TMR_MAX)
            tmr_q <= tmr_q + 11'd1;
      end
   end

   always_ff @(posedge clk_50 or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= IDLE;
         rpt_q    <= 1'b0;
         bitcnt_q <= '0;
         sr_q     <= '0;
         hold_q   <= '0;
         button_q <= IDLE_CODE;
         valid_q  <= 1'b0;
         rseen_q  <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         valid_q <= 1'b0;
         rseen_q <= 1'b0;
         err_q   <= 1'b0;
         if (timeout) begin
            state_q <= IDLE;
            err_q   <= 1'b1;
         end else begin
            case (state_q)
               IDLE:
                  if (fall_q) state_q <= LEAD_LOW;
               LEAD_LOW:
                  if (rise_q) begin
                     if (in_rng(tmr_q, 11'd800, 11'd1000)) state_q <= LEAD_HIGH;
                     else begin
                        state_q <= IDLE;
                        err_q   <= 1'b1;
                     end
                  end
               LEAD_HIGH:
                  if (fall_q) begin
                     if (in_rng(tmr_q, 11'd400, 11'd500)) begin
                        state_q  <= BIT_LOW;
                        bitcnt_q <= '0;
                        rpt_q    <= 1'b0;
                     end else if (in_rng(tmr_q, 11'd180, 11'd270)) begin
                        state_q <= STOP;
                        rpt_q   <= 1'b1;
                     end else begin
                        state_q <= IDLE;
                        err_q   <= 1'b1;
                     end
                  end
               BIT_LOW:
                  if (rise_q) begin
                     if (in_rng(tmr_q, 11'd40, 11'd72)) state_q <= BIT_HIGH;
                     else begin
                        state_q <= IDLE;
                        err_q   <= 1'b1;
                     end
                  end
               BIT_HIGH:
                  if (fall_q) begin
                     if (in_rng(tmr_q, 11'd40, 11'd72) || in_rng(tmr_q, 11'd140, 11'd200)) begin
                        sr_q     <= {in_rng(tmr_q, 11'd140, 11'd200), sr_q[31:1]};
                        bitcnt_q <= bitcnt_q + 6'd1;
                        state_q  <= (bitcnt_q == 6'd31) ? STOP : BIT_LOW;
                     end else begin
                        state_q <= IDLE;
                        err_q   <= 1'b1;
                     end
                  end
               STOP:
                  if (rise_q) begin
                     state_q <= IDLE;
                     if (!stop_ok || (!rpt_q && !sum_ok)) err_q <= 1'b1;
                  end
               default:
                  state_q <= IDLE;
            endcase
         end

         // A reload on completion takes priority over the hold countdown.
         if (frame_ok) begin
            hold_q   <= HOLD_LOAD;
            button_q <= sr_q[23:16];
            valid_q  <= 1'b1;
         end else if (rpt_ok) begin
            hold_q  <= HOLD_LOAD;
            rseen_q <= 1'b1;
         end else if (tick && hold_q != '0) begin
            hold_q <= hold_q - HW'(1);
            if (hold_q == HW'(1)) button_q <= IDLE_CODE;
         end
      end
   end
endmodule

// File: doc/nec_ir_decoder.md
Name: nec_ir_decoder

Overview:
Front-end stage that drives IR_button into the mode/drive FSM. It samples the raw active-low IR demodulator output and decodes NEC frames (leader, 32 data bits, stop burst). It validates the address and command checksums and presents the command byte as a level that is held while the remote key is held (repeat codes). The output returns to an idle code after release.

Parameters:
TICK_DIV, 500, clk_50 cycles per timing tick (10 us at 50 MHz)
HOLD_TICKS, 12000, ticks IR_button is held after last valid frame/repeat (120 ms)
IDLE_CODE, 8'h00, IR_button value when no key is active
CHECK_ADDR, 1, 1 = also require addr ^ addr_n == 8'hFF

Ports:
clk_50  in  1  system clock, 50 MHz
reset_n  in  1  asynchronous, active-low reset
ir_in  in  1  raw demodulator output, low during 38 kHz burst, asynchronous
IR_button  out  8  current command byte, or IDLE_CODE
code_valid  out  1  1-cycle pulse when a new full frame is accepted
repeat_seen  out  1  1-cycle pulse when an accepted repeat code extends the hold
frame_err  out  1  1-cycle pulse on timing violation or checksum failure

Behaviour:
- Interface: one clock, clk_50. reset_n is asynchronous and active-low.
- Reset values: IR_button=IDLE_CODE; code_valid, repeat_seen and frame_err = 0; FSM=IDLE; tick prescaler, phase timer, hold timer, shift register and bit count = 0.
- ir_in passes through a 2-flop synchronizer, then one edge-detect register. All timing uses the synchronized signal.
- Prescaler emits a tick every TICK_DIV cycles. The phase timer (11 bit, saturating at 2047) counts ticks and clears on every synchronized edge.
- FSM states: IDLE, LEAD_LOW, LEAD_HIGH, BIT_LOW, BIT_HIGH, STOP.
  - IDLE: a falling edge -> LEAD_LOW.
  - LEAD_LOW: on the rising edge, a duration of 800..1000 ticks -> LEAD_HIGH; any other duration -> error.
  - LEAD_HIGH: on the falling edge, 400..500 ticks -> BIT_LOW with bitcnt=0 (data frame). 180..270 ticks -> STOP with rpt flag set. Otherwise -> error.
  - BIT_LOW: on the rising edge, 40..72 ticks -> BIT_HIGH; otherwise -> error.
  - BIT_HIGH: on the falling edge, 40..72 ticks shifts in 0 and 140..200 ticks shifts in 1 (LSB first, into a 32-bit register). Otherwise -> error. If bitcnt reaches 32 -> STOP; else -> BIT_LOW.
  - STOP: on the rising edge, 40..72 ticks completes the frame and the FSM returns to IDLE; otherwise -> error.
- Timeout: in any non-IDLE state, if the timer exceeds the state's upper bound +1 before the expected edge -> error. This covers a stuck-low or stuck-high line.
- Error handling: frame_err pulses for 1 cycle, FSM -> IDLE, IR_button and hold timer are unchanged. If the line is still low when the FSM enters IDLE, it waits for a rising edge before accepting a new leader.
- Data frame completion: the frame is byte0=addr, byte1=addr_n, byte2=cmd, byte3=cmd_n.
  - Accept if cmd ^ cmd_n == 8'hFF and (CHECK_ADDR==0 or addr ^ addr_n == 8'hFF).
  - Accept: IR_button <= cmd, code_valid pulses, hold timer reloads to HOLD_TICKS.
  - Reject: frame_err pulses.
- Repeat completion: if the hold timer != 0, reload it to HOLD_TICKS and pulse repeat_seen; IR_button is unchanged. If the hold timer == 0, ignore the repeat (no pulse, no error).
- Hold timer decrements once per tick while nonzero. On the transition to 0, IR_button <= IDLE_CODE in the same cycle.
- Simultaneous events: a reload at completion wins over the tick decrement in the same cycle.
- Output timing:
  - Latency: IR_button, code_valid and repeat_seen update exactly 4 clk_50 cycles after the ir_in rising edge that ends the stop burst (2 sync + 1 edge detect + 1 register).
  - All outputs are registered; the pulses are exactly 1 cycle wide.
- Reset mid-frame: all state is cleared immediately, and the partial frame is discarded.

Test Plan:
- Valid frame addr=8'h00, cmd=8'h0F, nominal timing -> code_valid pulses once, IR_button=8'h0F 4 cycles after the stop-burst rising edge; after 120 ms with no input, IR_button=8'h00.
- Frame cmd=8'h13, then repeat codes every 108 ms, 5 times -> repeat_seen pulses 5 times, IR_button stays 8'h13 throughout, returns to 8'h00 120 ms after the last repeat.
- Frame with cmd=8'h10, cmd_n=8'hEE (bad checksum) -> frame_err pulses, code_valid stays 0, IR_button keeps its previous value.
- Timing edges: a bit space of 200 ticks decodes as 1; 201 ticks -> frame_err. A leader low of 799 ticks -> frame_err; 800 ticks is accepted.
- Repeat code with no prior frame (hold expired) -> no repeat_seen, no frame_err, IR_button=8'h00. ir_in held low for 15 ms -> frame_err once, FSM recovers and decodes the next valid frame.
- Assert reset_n low during bit 17 of a frame -> all outputs return to reset values asynchronously. After release, the next full frame cmd=8'h0F decodes correctly.
